// File: rtl/spi_controller.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one WIDTH-bit word per transaction.
// Frame: LEAD half-period, WIDTH sclk pulses, one idle-low half-period, TRAIL half-period.
module spi_controller #(
   parameter int WIDTH       = 8,
   parameter int HALF_PERIOD = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] txData,
   output logic [WIDTH-1:0] rxData,
   output logic             busy,
   output logic             done,
   output logic             sclk,
   output logic             cs_n,
   output logic             mosi,
   input  logic             miso
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int DW = $clog2(HALF_PERIOD + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);
   localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   state_t           state;
   logic [WIDTH-1:0] txReg;
   logic [WIDTH-1:0] rxReg;
   logic [BW-1:0]    bitCnt;
   logic [DW-1:0]    divCnt;
   logic             halfTick;

   assign halfTick = (divCnt == DIV_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         txReg  <= '0;
         rxReg  <= '0;
         rxData <= '0;
         bitCnt <= '0;
         divCnt <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         sclk   <= 1'b0;
         cs_n   <= 1'b1;
         mosi   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               divCnt <= '0;
               bitCnt <= '0;
               mosi   <= 1'b0;
               if (start) begin
                  txReg <= txData;
                  rxReg <= '0;
                  mosi  <= txData[WIDTH-1];
                  cs_n  <= 1'b0;
                  busy  <= 1'b1;
                  state <= LEAD;
               end
            end

            // First rising edge; miso is sampled on the same clk edge that raises sclk.
            LEAD: begin
               if (halfTick) begin
                  divCnt <= '0;
                  sclk   <= 1'b1;
                  rxReg  <= {rxReg[WIDTH-2:0], miso};
                  bitCnt <= bitCnt + 1'b1;
                  state  <= SHIFT;
               end else begin
                  divCnt <= divCnt + 1'b1;
               end
            end

            SHIFT: begin
               if (halfTick) begin
                  divCnt <= '0;
                  if (sclk) begin
                     sclk <= 1'b0;
                     if (bitCnt != LAST_BIT) begin
                        txReg <= {txReg[WIDTH-2:0], 1'b0};
                        mosi  <= txReg[WIDTH-2];
                     end
                  end else if (bitCnt == LAST_BIT) begin
                     // sclk has already stayed low one half-period after the last fall
                     state <= TRAIL;
                  end else begin
                     sclk   <= 1'b1;
                     rxReg  <= {rxReg[WIDTH-2:0], miso};
                     bitCnt <= bitCnt + 1'b1;
                  end
               end else begin
                  divCnt <= divCnt + 1'b1;
               end
            end

            TRAIL: begin
               if (halfTick) begin
                  divCnt <= '0;
                  bitCnt <= '0;
                  cs_n   <= 1'b1;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  mosi   <= 1'b0;
                  rxData <= rxReg;
                  state  <= IDLE;
               end else begin
                  divCnt <= divCnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Directed + randomized checks of spi_controller (WIDTH=8, HALF_PERIOD=2) against a
// frame-level model: latency (2*W+2)*HP, MSB-first bit order, one done per frame.
module tb_spi_controller;

   localparam int W   = 8;
   localparam int HP  = 2;
   localparam int LAT = (2 * W + 2) * HP;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] txData;
   logic [W-1:0] rxData;
   logic         busy;
   logic         done;
   logic         sclk;
   logic         cs_n;
   logic         mosi;
   logic         miso;

   int nCmp = 0;
   int nErr = 0;

   // peripheral / monitor state
   int           riseCnt = 0;
   int           fallCnt = 0;
   int           doneCnt = 0;
   int           csLowCnt = 0;
   logic [W-1:0] periphOut = '0;
   bit           loopback = 1'b1;
   logic [W-1:0] misoWord = '0;
   int           fallBase = 0;

   spi_controller #(.WIDTH(W), .HALF_PERIOD(HP)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .txData (txData),
      .rxData (rxData),
      .busy   (busy),
      .done   (done),
      .sclk   (sclk),
      .cs_n   (cs_n),
      .mosi   (mosi),
      .miso   (miso)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shift-register peripheral: captures mosi on sclk rise (parallelLoad=0)
   always @(posedge sclk) begin
      riseCnt   = riseCnt + 1;
      periphOut = {periphOut[W-2:0], mosi};
   end
   always @(negedge sclk) fallCnt = fallCnt + 1;

   always @(negedge clk) begin
      if (done) doneCnt = doneCnt + 1;
      if (!cs_n) csLowCnt = csLowCnt + 1;
   end

   // Mode-0 slave: bit k of the word is presented after k falling edges
   always @* begin
      int idx;
      idx = fallCnt - fallBase;
      if (loopback) miso = mosi;
      else if (idx >= 0 && idx < W) miso = misoWord[W-1-idx];
      else miso = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input logic [W-1:0] tx, input bit loop, input logic [W-1:0] mw,
                       input int glitchAt, input string tag);
      logic [W-1:0] expRx, prevRx;
      int r0, d0, c0, lat;
      bit seen;
      expRx = loop ? tx : mw;
      @(negedge clk);
      prevRx   = rxData;
      loopback = loop;
      misoWord = mw;
      fallBase = fallCnt;
      r0 = riseCnt; d0 = doneCnt; c0 = csLowCnt;
      start  = 1'b1;
      txData = tx;
      @(negedge clk);
      start  = 1'b0;
      txData = 8'($urandom);
      check({tag, ".busyAccept"}, 32'(busy), 32'(1));
      check({tag, ".csAccept"}, 32'(cs_n), 32'(0));
      check({tag, ".mosiMsb"}, 32'(mosi), 32'(tx[W-1]));
      lat = 0;
      seen = 1'b0;
      while (!seen && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == glitchAt) begin
            start  = 1'b1;
            txData = 8'h00;
         end else begin
            start = 1'b0;
         end
         if (lat == 10) check({tag, ".rxStable"}, 32'(rxData), 32'(prevRx));
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({tag, ".doneSeen"}, 32'(seen), 32'(1));
      check({tag, ".latency"}, 32'(lat), 32'(LAT));
      check({tag, ".rxData"}, 32'(rxData), 32'(expRx));
      check({tag, ".rises"}, 32'(riseCnt - r0), 32'(W));
      check({tag, ".mosiSeq"}, 32'(periphOut), 32'(tx));
      check({tag, ".csDone"}, 32'(cs_n), 32'(1));
      @(negedge clk);
      check({tag, ".donePulse"}, 32'(done), 32'(0));
      check({tag, ".doneCount"}, 32'(doneCnt - d0), 32'(1));
      check({tag, ".csLowCycles"}, 32'(csLowCnt - c0), 32'(LAT));
      check({tag, ".mosiIdle"}, 32'(mosi), 32'(0));
   endtask

   initial begin
      int g, r0, d0, lat;
      bit seen;
      logic [W-1:0] tx, mw;
      bit lb;

      reset_n = 1'b1;
      start   = 1'b0;
      txData  = '0;
      #3 reset_n = 1'b0;
      #1;
      check("rst.sclk", 32'(sclk), 32'(0));
      check("rst.cs_n", 32'(cs_n), 32'(1));
      check("rst.busy", 32'(busy), 32'(0));
      check("rst.done", 32'(done), 32'(0));
      check("rst.mosi", 32'(mosi), 32'(0));
      check("rst.rxData", 32'(rxData), 32'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      xfer(8'hA5, 1'b1, 8'h00, 0, "loopA5");
      xfer(8'h3C, 1'b0, 8'hFF, 0, "miso1");
      xfer(8'h3C, 1'b0, 8'h00, 0, "miso0");
      xfer(8'hC3, 1'b1, 8'h00, 5, "ignoreStart");

      // back-to-back with start held high
      @(negedge clk);
      loopback = 1'b1;
      start  = 1'b1;
      txData = 8'h81;
      lat = 0; seen = 1'b0;
      while (!seen && lat < 200) begin
         @(negedge clk);
         lat++;
         if (done) seen = 1'b1;
      end
      check("b2b.done1", 32'(seen), 32'(1));
      check("b2b.rx1", 32'(rxData), 32'(8'h81));
      check("b2b.csHigh", 32'(cs_n), 32'(1));
      txData = 8'h7E;
      @(negedge clk);
      start  = 1'b0;
      txData = 8'($urandom);
      check("b2b.csLowAgain", 32'(cs_n), 32'(0));
      check("b2b.busy2", 32'(busy), 32'(1));
      g = 1; seen = 1'b0;
      while (!seen && g < 200) begin
         @(negedge clk);
         g++;
         if (done) seen = 1'b1;
      end
      check("b2b.done2", 32'(seen), 32'(1));
      check("b2b.gap", 32'(g), 32'(LAT + 1));
      check("b2b.rx2", 32'(rxData), 32'(8'h7E));
      @(negedge clk);

      // reset after the 4th sclk rise
      loopback = 1'b1;
      r0 = riseCnt; d0 = doneCnt;
      start  = 1'b1;
      txData = 8'hE7;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while ((riseCnt - r0) < 4 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check("abort.reached4", 32'(riseCnt - r0), 32'(4));
      reset_n = 1'b0;
      #1;
      check("abort.sclk", 32'(sclk), 32'(0));
      check("abort.cs_n", 32'(cs_n), 32'(1));
      check("abort.busy", 32'(busy), 32'(0));
      check("abort.rxData", 32'(rxData), 32'(0));
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (LAT) @(negedge clk);
      check("abort.noDone", 32'(doneCnt - d0), 32'(0));
      xfer(8'h5A, 1'b1, 8'h00, 0, "afterAbort");

      xfer(8'h96, 1'b1, 8'h00, 0, "periph96");
      check("periph.parallelOut", 32'(periphOut), 32'(8'h96));

      for (int i = 0; i < 6; i++) begin
         tx = 8'($urandom);
         mw = 8'($urandom);
         lb = 1'($urandom_range(0, 1));
         xfer(tx, lb, mw, (i % 2 == 0) ? int'($urandom_range(2, 30)) : 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
